mem_ctrl: RTL
=============

# mem_ctrl

Memory controller and arbiter sharing the single byte-wide RAM port between instruction fetch (IF) and the MEM stage (loads/stores). It sequences multi-byte accesses into per-byte RAM cycles, assembles little-endian read data, and aborts in-flight fetches when EX resolves a taken branch or jump. It sits between the IF/MEM pipeline stages and the external RAM.

## Interface

Parameters:
- ADDR_W, 32, address width for requester and RAM addresses.

Ports:
- clk  in  1  clock. All state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_i  in  1  IF requests a 4-byte instruction read.
- if_addr_i  in  ADDR_W  IF byte address.
- if_done_o  out  1  one-cycle pulse; if_data_o valid.
- if_data_o  out  32  fetched word.
- mem_req_i  in  1  MEM requests an access.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_width_i  in  2  00 byte, 01 half, 10/11 word.
- mem_addr_i  in  ADDR_W  MEM byte address.
- mem_wdata_i  in  32  store data; byte k is bits [8k+7:8k].
- mem_done_o  out  1  one-cycle pulse; access complete and mem_rdata_o valid for loads.
- mem_rdata_o  out  32  zero-extended load data. Sign extension is done in MEM.
- flush_i  in  1  taken branch/jump from EX. Cancels IF traffic.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_wr_o  out  1  1 = write ram_dout_o.
- ram_dout_o  out  8  RAM write byte.
- ram_din_i  in  8  RAM read byte. Valid in the cycle after its address is driven.

## Operation

- FSM states:
  - IDLE: no access in progress.
  - READ: load or fetch in progress.
  - WRITE: store in progress.
- Registers:
  - owner: IF or MEM.
  - base address.
  - n: byte count 1/2/4.
  - issue counter: 0..n.
  - capture counter: 0..n.
  - data assembly register.
- Arbitration in IDLE:
  - MEM wins over IF when both request.
  - No preemption once a transaction starts.
  - A requester whose done_o is high in the current cycle is not sampled.
- Flush and IF acceptance:
  - An IF request is not accepted in a cycle where flush_i is high.
- Accept edge E0:
  - Latch the request.
  - ram_addr_o <= addr.
  - For a store: ram_wr_o <= 1 and ram_dout_o <= byte 0.
  - Go to READ or WRITE.
- READ:
  - At edge E(k), for k < n: drive ram_addr_o <= addr+k.
  - At edge E(k+2): capture ram_din_i into byte k.
  - After the last capture, at E(n+1): done_o <= 1, data_o <= assembled value (upper unused bytes 0), ram_addr_o <= 0, next state IDLE.
- WRITE:
  - At edge E(k), for k < n: drive addr+k and byte k.
  - At E(n): ram_wr_o <= 0, ram_addr_o <= 0, mem_done_o <= 1, next state IDLE.
- Address arithmetic is ADDR_W-bit modulo (0xFFFFFFFF+1 wraps to 0).
- if_data_o and mem_rdata_o hold their value until the next done pulse of the same port.
- Flush:
  - flush_i high while owner = IF (READ) returns to IDLE at the next edge.
  - ram_addr_o <= 0 and no if_done_o pulse.
  - A new request may be accepted at the following edge.
  - flush_i has no effect on MEM transactions.
  - flush_i in the same cycle as an if_done_o pulse has no effect; the pulse still occurs.
- ram_wr_o is never high in READ or IDLE.
- Reset (rst = 0, any time including mid-transaction):
  - State IDLE, all counters and the assembly register 0.
  - All outputs 0: if_done_o, if_data_o, mem_done_o, mem_rdata_o, ram_addr_o, ram_wr_o, ram_dout_o.
  - The in-flight transaction is dropped with no done pulse.

## Timing

- E0 is the rising edge at which a request is sampled in IDLE.
- Read, n bytes: done_o is high in the cycle after E(n+1).
  - Word fetch or load: 5 edges.
  - Half: 3 edges.
  - Byte: 2 edges.
- Write, n bytes: mem_done_o is high in the cycle after E(n).
  - Word: 4 edges.
  - Half: 2 edges.
  - Byte: 1 edge.
- Done pulses last exactly one cycle.
- Throughput: the next request is sampled no earlier than the edge ending the done cycle. One idle cycle separates back-to-back transactions.
- Requesters hold req and operands stable until they see done. Operands are latched at E0 only.

## Test plan

- Word fetch: preload RAM 0x100..0x103 = 13,00,50,00; if_req_i at 0x100.
  - Required: if_done_o one-cycle pulse 5 edges after acceptance.
  - if_data_o = 0x00500013; ram_wr_o stays 0.
- Simultaneous requests: mem load byte 0x200 (RAM = 0xF0) and IF fetch at 0x104 in the same cycle.
  - Required: MEM served first; mem_rdata_o = 0x000000F0.
  - IF is accepted after the MEM done cycle; if_done_o follows.
- Store half: 0xBEEF to 0x3FE.
  - Required: ram_wr_o high for 2 cycles, writing 0x3FE = 0xEF and 0x3FF = 0xBE.
  - mem_done_o pulses 2 edges after acceptance.
- Flush: pulse flush_i 2 cycles into a fetch, with MEM asserting a load the next cycle.
  - Required: no if_done_o; the controller returns to IDLE; the MEM load completes normally.
  - A flush during a MEM store changes nothing.
- Wrap and reset: word load at 0xFFFFFFFE.
  - Required: RAM addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 in order.
  - Repeat with rst asserted after 2 edges: all outputs 0 immediately, no done pulse, a new request is accepted after release.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and sequencer for the single byte-wide RAM port shared by instruction fetch
// (IF) and the MEM stage. Multi-byte accesses are split into per-byte RAM cycles. Read bytes are
// assembled little-endian. A flush from EX drops an in-flight fetch.
//
// Ports:
//   clk, rst           clock and asynchronous active-low reset
//   if_req_i/addr_i    4-byte instruction read request
//   if_done_o/data_o   one-cycle completion pulse and fetched word (held until the next pulse)
//   mem_req_i/we_i     MEM access request (we=1 store, we=0 load)
//   mem_width_i        00 byte, 01 half, 1x word
//   mem_addr_i/wdata_i MEM byte address and store data
//   mem_done_o/rdata_o one-cycle completion pulse and zero-extended load data
//   flush_i            taken branch/jump; cancels IF traffic only
//   ram_addr_o/wr_o    RAM byte address and write strobe
//   ram_dout_o         RAM write byte
//   ram_din_i          RAM read byte, valid the cycle after its address is driven
module mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_width_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e            state_q, state_d;
  logic              owner_mem_q, owner_mem_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        issue_q, issue_d;
  logic [2:0]        cap_q, cap_d;
  // Low for the first READ edge: no read data is on ram_din_i yet.
  logic              prime_q, prime_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       asm_next;
  logic              if_done_q, if_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;

  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Current assembly with the byte arriving this cycle merged into lane cap_q.
  assign asm_next = asm_q | (32'(ram_din_i) << {cap_q[1:0], 3'b000});

  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    base_d      = base_q;
    n_d         = n_q;
    issue_d     = issue_q;
    cap_d       = cap_q;
    prime_d     = prime_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = ram_wr_q;
    ram_dout_d  = ram_dout_q;

    case (state_q)
      StIdle: begin
        // A requester still showing its done pulse is ignored so it is not served twice.
        if (mem_req_i && !mem_done_q) begin
          owner_mem_d = 1'b1;
          base_d      = mem_addr_i;
          n_d         = width_bytes(mem_width_i);
          wdata_d     = mem_wdata_i;
          issue_d     = 3'd1;
          cap_d       = 3'd0;
          prime_d     = 1'b0;
          asm_d       = 32'd0;
          ram_addr_d  = mem_addr_i;
          if (mem_we_i) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata_i[7:0];
            state_d    = StWrite;
          end else begin
            state_d = StRead;
          end
        end else if (if_req_i && !if_done_q && !flush_i) begin
          owner_mem_d = 1'b0;
          base_d      = if_addr_i;
          n_d         = 3'd4;
          issue_d     = 3'd1;
          cap_d       = 3'd0;
          prime_d     = 1'b0;
          asm_d       = 32'd0;
          ram_addr_d  = if_addr_i;
          state_d     = StRead;
        end
      end

      StRead: begin
        if (!owner_mem_q && flush_i) begin
          ram_addr_d = '0;
          state_d    = StIdle;
        end else begin
          if (issue_q < n_q) begin
            ram_addr_d = base_q + ADDR_W'(issue_q);
            issue_d    = issue_q + 3'd1;
          end
          if (!prime_q) begin
            prime_d = 1'b1;
          end else begin
            asm_d = asm_next;
            cap_d = cap_q + 3'd1;
            if (cap_q == n_q - 3'd1) begin
              ram_addr_d = '0;
              state_d    = StIdle;
              if (owner_mem_q) begin
                mem_done_d  = 1'b1;
                mem_rdata_d = asm_next;
              end else begin
                if_done_d = 1'b1;
                if_data_d = asm_next;
              end
            end
          end
        end
      end

      StWrite: begin
        if (issue_q < n_q) begin
          ram_addr_d = base_q + ADDR_W'(issue_q);
          ram_dout_d = wdata_q[{issue_q[1:0], 3'b000} +: 8];
          issue_d    = issue_q + 3'd1;
        end else begin
          ram_wr_d   = 1'b0;
          ram_addr_d = '0;
          mem_done_d = 1'b1;
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_mem_q <= 1'b0;
      base_q      <= '0;
      n_q         <= 3'd0;
      issue_q     <= 3'd0;
      cap_q       <= 3'd0;
      prime_q     <= 1'b0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      if_done_q   <= 1'b0;
      if_data_q   <= 32'd0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= 32'd0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      base_q      <= base_d;
      n_q         <= n_d;
      issue_q     <= issue_d;
      cap_q       <= cap_d;
      prime_q     <= prime_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  assign if_done_o   = if_done_q;
  assign if_data_o   = if_data_q;
  assign mem_done_o  = mem_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wr_o    = ram_wr_q;
  assign ram_dout_o  = ram_dout_q;

endmodule
